// File: rtl/iic_pkg.sv
// Shared I2C engine definitions: phase timing default, state encoding and ACK levels.
package iic_pkg;

    localparam int unsigned DELAY_DEFAULT = 5;
    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned BIT_CNT_W     = 4;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOW      = 3'd1,
        HIGH     = 3'd2,
        ACK_LOW  = 3'd3,
        ACK_HIGH = 3'd4,
        TAIL     = 3'd5,
        DONE     = 3'd6
    } iic_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iic_phase_timer.sv
// DELAY-cycle phase counter: restarts on every state change and flags the final cycle.
module iic_phase_timer
    import iic_pkg::*;
#(
    parameter int unsigned DELAY = DELAY_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    input  logic clear,
    output logic last_c
);

    localparam int unsigned CW = cnt_width(DELAY);

    logic [CW-1:0] phase;

    assign last_c = run && (phase == CW'(DELAY - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase <= '0;
        end else if (!run || clear) begin
            phase <= '0;
        end else begin
            phase <= phase + CW'(1);
        end
    end

endmodule

// File: rtl/myiic_readbyte.sv
// I2C master-receive byte engine: clocks in 8 bits MSB first, then drives ACK/NACK.
module myiic_readbyte
    import iic_pkg::*;
#(
    parameter int unsigned DELAY = DELAY_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en_read,
    input  logic       ack_en,
    inout  wire        sda,
    output logic       scl,
    output logic       sda_dir,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done
);

    iic_state_e           state, state_nxt;
    logic                 ack_latched, ack_nxt;
    logic [7:0]           shift, shift_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic                 sda_out, sda_out_nxt;
    logic                 scl_nxt, sda_dir_nxt, busy_nxt, done_nxt;
    logic [7:0]           rx_nxt;
    logic                 timer_run, last_c;

    assign sda       = sda_dir ? sda_out : 1'bz;
    assign timer_run = (state != IDLE) && (state != DONE);

    iic_phase_timer #(
        .DELAY (DELAY)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .run    (timer_run),
        .clear  (state_nxt != state),
        .last_c (last_c)
    );

    // Next state and the registered output values that belong to it.
    always_comb begin
        state_nxt   = state;
        ack_nxt     = ack_latched;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        scl_nxt     = 1'b1;
        sda_dir_nxt = 1'b0;
        sda_out_nxt = NACK;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        rx_nxt      = rx_data;

        unique case (state)
            IDLE: begin
                if (en_read) begin
                    state_nxt   = LOW;
                    ack_nxt     = ack_en;
                    shift_nxt   = '0;
                    bit_cnt_nxt = '0;
                end
            end
            LOW: begin
                if (last_c) state_nxt = HIGH;
            end
            HIGH: begin
                if (last_c) begin
                    shift_nxt   = {shift[6:0], sda};
                    bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    state_nxt   = (bit_cnt_nxt == BIT_CNT_W'(BITS_PER_BYTE)) ? ACK_LOW : LOW;
                end
            end
            ACK_LOW: begin
                if (last_c) state_nxt = ACK_HIGH;
            end
            ACK_HIGH: begin
                if (last_c) state_nxt = TAIL;
            end
            TAIL: begin
                if (last_c) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        unique case (state_nxt)
            LOW, TAIL: scl_nxt = 1'b0;
            ACK_LOW: begin
                scl_nxt     = 1'b0;
                sda_dir_nxt = 1'b1;
                sda_out_nxt = ack_nxt ? ACK : NACK;
            end
            ACK_HIGH: begin
                sda_dir_nxt = 1'b1;
                sda_out_nxt = ack_nxt ? ACK : NACK;
            end
            default: scl_nxt = 1'b1;
        endcase

        busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
        if (state_nxt == DONE) begin
            done_nxt = 1'b1;
            rx_nxt   = shift_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            ack_latched <= 1'b0;
            shift       <= '0;
            bit_cnt     <= '0;
            sda_out     <= 1'b1;
            scl         <= 1'b1;
            sda_dir     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rx_data     <= 8'h00;
        end else begin
            state       <= state_nxt;
            ack_latched <= ack_nxt;
            shift       <= shift_nxt;
            bit_cnt     <= bit_cnt_nxt;
            sda_out     <= sda_out_nxt;
            scl         <= scl_nxt;
            sda_dir     <= sda_dir_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            rx_data     <= rx_nxt;
        end
    end

endmodule

// File: doc/myiic_readbyte.md
Name: myiic_readbyte

Overview:
- I2C master-receive byte engine; the receive counterpart to the team's master byte writer.
- Generates SCL, releases SDA, and samples 8 data bits MSB first from the slave.
- Drives ACK (continue) or NACK (last byte) in the 9th clock, then returns rx_data with a one-cycle done pulse.
- A sequencer issues START, address and STOP through the writer; this block only reads data bytes.

Parameters:
- DELAY, 5: clk cycles per SCL phase (low or high). With the 1 MHz clk, 5 cycles = 5 us per phase. Legal range 2..2^20.

Ports:
- clk  in  1  system clock (1 MHz nominal)
- rstn  in  1  asynchronous reset, active low
- en_read  in  1  start one byte read; sampled only in IDLE
- ack_en  in  1  1 = drive ACK (SDA low) after the byte, 0 = NACK; latched with en_read
- sda  inout  1  I2C data line; driven only when sda_dir=1
- scl  out  1  I2C clock (registered)
- sda_dir  out  1  1 = block drives sda, 0 = released (sda = 1'bz)
- rx_data  out  8  last received byte, held until the next done
- busy  out  1  high from the cycle after en_read is accepted until DONE
- done  out  1  one-cycle pulse, byte complete

Behaviour:
- Reset (asynchronous, any time including mid-byte):
  - state=IDLE, scl=1, sda_dir=0, sda_out=1.
  - rx_data=8'h00, busy=0, done=0.
  - Bit counter and phase counter cleared.
- Phase counter:
  - Counts 0..DELAY-1 in each non-IDLE/non-DONE state.
  - Wraps to 0 on every state change, so each phase lasts exactly DELAY cycles.
- States, in order:
  - IDLE: scl=1, sda_dir=0. If en_read=1 at a clk edge: latch ack_en, clear shift register and bit count, go to LOW. en_read=0 stays in IDLE.
  - LOW: scl=0, sda_dir=0. After DELAY cycles go to HIGH.
  - HIGH: scl=1, sda_dir=0.
    - In the last cycle (phase==DELAY-1), sample sda into the shift register: shift left, sda enters bit 0; increment bit count.
    - If bit count reaches 8, go to ACK_LOW, otherwise go to LOW.
  - ACK_LOW: scl=0, sda_dir=1, sda_out=~ack_latched. Lasts DELAY cycles.
  - ACK_HIGH: scl=1, SDA still driven. Lasts DELAY cycles.
  - TAIL: scl=0, sda_dir=0, releasing SDA while SCL is low. Lasts DELAY cycles.
  - DONE: one cycle. rx_data <= shift register, done=1, busy=0, scl=1, sda_dir=0. Next state is IDLE.
- SDA only changes while SCL is low, so no spurious START or STOP is generated.
- Latency:
  - 19 phases (16 data, ACK_LOW, ACK_HIGH, TAIL) = 19*DELAY cycles after the accepting edge.
  - done is high in cycle 19*DELAY+1.
  - With DELAY=5, done is in cycle 96.
- en_read while busy or in DONE is ignored; no queueing. ack_en changes after acceptance have no effect.
- rx_data changes only in DONE. A reset mid-byte discards the partial byte.
- The bit count is 4 bits and never exceeds 8.
- SDA is sampled raw with no synchronizer; the slave holds data through the SCL high phase.

Decomposition:
- Package iic_pkg holds:
  - default DELAY;
  - the state encoding (IDLE, LOW, HIGH, ACK_LOW, ACK_HIGH, TAIL, DONE), shared with the writer's encodings;
  - ACK=1'b0 and NACK=1'b1 constants.
- One natural sub-module, iic_phase_timer: DELAY-cycle counter with clear-on-state-change and a last-cycle flag. The writer can reuse it.

Test Plan (DELAY=5, slave model drives sda during LOW phases):
- en_read=1, ack_en=1, slave sends 8'hA5 -> rx_data=8'hA5; done pulses exactly at cycle 96; SDA driven 0 during cycles 81-90; busy high in cycles 1-95.
- ack_en=0, slave sends 8'h3C -> rx_data=8'h3C; sda_dir=1 with sda_out=1 (NACK) during ACK phases; sda released in TAIL.
- Two back-to-back reads, 8'hFF then 8'h00, with en_read reasserted on the done cycle +1 -> rx_data=8'hFF then 8'h00; 20 SCL rising edges in total.
- en_read pulsed again at cycle 40 mid-byte -> ignored; a single done at cycle 96; rx_data correct.
- rstn asserted at cycle 50 -> immediately scl=1, sda_dir=0, rx_data=8'h00, busy=0; no done. A new read after release completes normally.
- Protocol checker on every transfer -> sda never changes while scl=1, and scl high/low phases are exactly 5 cycles.
